// File: rtl/lc3_console_tx_if.sv
// Display-data write port and UART/FIFO status of the LC3 console transmitter.
// The master side is the MIO display path; the slave side is the transmitter.
interface lc3_console_tx_if #(
    parameter int FIFO_AW = 3
);
    logic [15:0]      DDR;
    logic             WR_DDR;
    logic             TXD;
    logic             TX_BUSY;
    logic             FIFO_FULL;
    logic [FIFO_AW:0] FIFO_COUNT;
    logic             OVERFLOW;

    modport master (
        output DDR,
        output WR_DDR,
        input  TXD,
        input  TX_BUSY,
        input  FIFO_FULL,
        input  FIFO_COUNT,
        input  OVERFLOW
    );

    modport slave (
        input  DDR,
        input  WR_DDR,
        output TXD,
        output TX_BUSY,
        output FIFO_FULL,
        output FIFO_COUNT,
        output OVERFLOW
    );
endinterface

// File: rtl/lc3_console_tx.sv
// LC3 console transmitter: buffers display-register writes in a FIFO and
// serialises each byte as an 8N1 UART frame, LSB first, on a registered TXD.
module lc3_console_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic           clk,
    input  logic           reset,
    lc3_console_tx_if.slave bus
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE   = BAUD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_overflow;

    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_txd;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_tc;
    logic                 w_txd_next;
    logic                 w_unused_ddr_hi;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == COUNT_FULL);
    assign w_baud_tc = (r_baud == BAUD_LAST);

    // A full FIFO still takes a write in the cycle the transmitter pops a byte.
    assign w_push = bus.WR_DDR && (!w_full || w_pop);

    assign w_unused_ddr_hi = ^bus.DDR[15:8];

    // NOTE: state and datapath flops use non-blocking assignments so every
    // always_ff samples the same pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: each always_comb assigns every output first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty)                       w_next_state = START;
            START:   if (w_baud_tc)                      w_next_state = DATA;
            DATA:    if (w_baud_tc && r_bit_idx == 3'd7) w_next_state = STOP;
            STOP:    if (w_baud_tc)                      w_next_state = IDLE;
            default:                                     w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_txd_next = 1'b1;
        case (r_state)
            IDLE:    w_pop      = !w_empty;
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = r_shift[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    // NOTE: the character storage has no reset; the pointers and count alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.DDR[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
            if (bus.WR_DDR && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Baud counter and shifter run only while a frame is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_txd <= w_txd_next;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_baud    <= '0;
                r_bit_idx <= '0;
            end else if (r_state != IDLE) begin
                if (w_baud_tc) begin
                    r_baud <= '0;
                    if (r_state == DATA) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + BAUD_ONE;
                end
            end
        end
    end

    assign bus.TXD        = r_txd;
    assign bus.TX_BUSY    = (r_state != IDLE) || !w_empty;
    assign bus.FIFO_FULL  = w_full;
    assign bus.FIFO_COUNT = r_count;
    assign bus.OVERFLOW   = r_overflow;
endmodule

// File: tb/tb_lc3_console_tx.sv
// Directed bench for lc3_console_tx at CLKS_PER_BIT=4, depth 8, with a UART
// line decoder that records each received byte and its start-bit cycle.
module tb_lc3_console_tx;
    localparam int N  = 4;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lc3_console_tx_if #(.FIFO_AW(AW)) bus ();

    lc3_console_tx #(
        .CLKS_PER_BIT(N),
        .FIFO_AW     (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b1;
    logic        mon_prev = 1'b1;
    logic [7:0]  mon_byte;
    int          mon_t0;
    logic [7:0]  rx_q[$];
    int          rx_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples each bit at its centre, N/2 cycles into the period.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && mon_prev === 1'b1 && bus.TXD === 1'b0) begin
                mon_t0 = cyc;
                repeat (N / 2) @(negedge clk);
                check("start_bit", 32'(bus.TXD), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    mon_byte[i] = bus.TXD;
                end
                repeat (N) @(negedge clk);
                check("stop_bit", 32'(bus.TXD), 1);
                rx_q.push_back(mon_byte);
                rx_cyc.push_back(mon_t0);
            end
            mon_prev = bus.TXD;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one write cycle; returns on the negedge after the sampling edge.
    task automatic put(input logic [15:0] d);
        bus.DDR    = d;
        bus.WR_DDR = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_rx(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'h1ff;
        check(tag, got, 32'(exp));
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (bus.TX_BUSY !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 32'(bus.TX_BUSY), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    logic [9:0] lv;
    logic [7:0] v;
    int         peak;
    int         lows;
    int         busy_seen;

    initial begin
        bus.DDR    = '0;
        bus.WR_DDR = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd",   32'(bus.TXD), 1);
        check("rst_busy",  32'(bus.TX_BUSY), 0);
        check("rst_full",  32'(bus.FIFO_FULL), 0);
        check("rst_count", 32'(bus.FIFO_COUNT), 0);
        check("rst_ovf",   32'(bus.OVERFLOW), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single character 0x41: start, 1,0,0,0,0,0,1,0, stop.
        clear_rx();
        put(16'hAB41);
        bus.WR_DDR = 1'b0;
        check("t1_count_k", 32'(bus.FIFO_COUNT), 1);
        check("t1_txd_k",   32'(bus.TXD), 1);
        check("t1_busy_k",  32'(bus.TX_BUSY), 1);
        @(negedge clk);
        check("t1_txd_k1",   32'(bus.TXD), 1);
        check("t1_count_k1", 32'(bus.FIFO_COUNT), 0);
        @(negedge clk);
        lv = 10'b1_0100_0001_0;
        for (int i = 0; i < 40; i++) begin
            check("t1_level", 32'(bus.TXD), 32'(lv[i / N]));
            if (i == 38) check("t1_busy_hold", 32'(bus.TX_BUSY), 1);
            if (i == 39) check("t1_busy_drop", 32'(bus.TX_BUSY), 0);
            if (i < 39) @(negedge clk);
        end
        @(negedge clk);
        check("t1_txd_idle", 32'(bus.TXD), 1);
        wait_rx(1, 20);
        check_rx("t1_byte", 0, 8'h41);
        wait_idle(50);

        // Burst 'H','i','!' on consecutive cycles.
        clear_rx();
        peak = 0;
        put(16'h0048);
        if (int'(bus.FIFO_COUNT) > peak) peak = int'(bus.FIFO_COUNT);
        put(16'hFF69);
        if (int'(bus.FIFO_COUNT) > peak) peak = int'(bus.FIFO_COUNT);
        put(16'h1221);
        bus.WR_DDR = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (int'(bus.FIFO_COUNT) > peak) peak = int'(bus.FIFO_COUNT);
            @(negedge clk);
        end
        check("t2_peak", 32'(peak), 2);
        wait_rx(3, 200);
        check_rx("t2_b0", 0, 8'h48);
        check_rx("t2_b1", 1, 8'h69);
        check_rx("t2_b2", 2, 8'h21);
        if (rx_cyc.size() >= 3) begin
            check("t2_period01", 32'(rx_cyc[1] - rx_cyc[0]), 41);
            check("t2_period12", 32'(rx_cyc[2] - rx_cyc[1]), 41);
        end
        wait_idle(100);

        // Ten writes 0x30..0x39 while idle: 0x39 finds the FIFO full.
        clear_rx();
        for (int i = 0; i < 10; i++) begin
            v = 8'(32'h30 + i);
            put({8'h00, v});
        end
        bus.WR_DDR = 1'b0;
        check("t3_ovf",   32'(bus.OVERFLOW), 1);
        check("t3_full",  32'(bus.FIFO_FULL), 1);
        check("t3_count", 32'(bus.FIFO_COUNT), 8);
        wait_rx(9, 9 * 41 + 60);
        for (int i = 0; i < 9; i++) begin
            v = 8'(32'h30 + i);
            check_rx("t3_byte", i, v);
        end
        wait_idle(100);
        check("t3_ovf_sticky", 32'(bus.OVERFLOW), 1);
        check("t3_count_end",  32'(bus.FIFO_COUNT), 0);
        check("t3_full_end",   32'(bus.FIFO_FULL), 0);

        // Full FIFO plus a write on the pop cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_ovf_rst", 32'(bus.OVERFLOW), 0);
        clear_rx();
        put(16'h0055);
        for (int i = 0; i < 8; i++) begin
            v = 8'(32'h61 + i);
            put({8'h80, v});
        end
        bus.WR_DDR = 1'b0;
        check("t4_count_full", 32'(bus.FIFO_COUNT), 8);
        check("t4_full",       32'(bus.FIFO_FULL), 1);
        repeat (33) @(negedge clk);
        check("t4_count_prepop", 32'(bus.FIFO_COUNT), 8);
        put(16'h007A);
        bus.WR_DDR = 1'b0;
        check("t4_count_pop", 32'(bus.FIFO_COUNT), 8);
        check("t4_ovf_pop",   32'(bus.OVERFLOW), 0);
        check("t4_full_pop",  32'(bus.FIFO_FULL), 1);
        wait_rx(10, 10 * 41 + 60);
        check_rx("t4_b0", 0, 8'h55);
        for (int i = 0; i < 8; i++) begin
            v = 8'(32'h61 + i);
            check_rx("t4_fill", i + 1, v);
        end
        check_rx("t4_b9", 9, 8'h7A);
        wait_idle(100);
        check("t4_ovf_end", 32'(bus.OVERFLOW), 0);

        // Reset during data bit 3 of 0xF7 with four bytes queued.
        mon_en = 1'b0;
        put(16'h00F7);
        put(16'h0011);
        put(16'h0022);
        put(16'h0033);
        put(16'h0044);
        bus.WR_DDR = 1'b0;
        repeat (14) @(negedge clk);
        check("t5_bit3",     32'(bus.TXD), 0);
        check("t5_count_pre", 32'(bus.FIFO_COUNT), 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_txd",   32'(bus.TXD), 1);
        check("t5_count", 32'(bus.FIFO_COUNT), 0);
        check("t5_busy",  32'(bus.TX_BUSY), 0);
        lows      = 0;
        busy_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.TXD !== 1'b1) lows++;
            if (bus.TX_BUSY !== 1'b0) busy_seen++;
        end
        check("t5_no_frames", 32'(lows), 0);
        check("t5_no_busy",   32'(busy_seen), 0);
        mon_en = 1'b1;

        // Twenty characters spaced 30 cycles apart; pointers wrap twice.
        clear_rx();
        for (int i = 0; i < 20; i++) begin
            v = 8'(i * 37 + 5);
            put({8'hC3, v});
            bus.WR_DDR = 1'b0;
            repeat (29) @(negedge clk);
        end
        wait_rx(20, 600);
        for (int i = 0; i < 20; i++) begin
            v = 8'(i * 37 + 5);
            check_rx("t6_byte", i, v);
        end
        check("t6_ovf", 32'(bus.OVERFLOW), 0);
        wait_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
